id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all operand/PC buses.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 flush  input  1  discard all held and incoming instructions.
REQ-007 pc, rs1_data, rs2_data, imm  input  XLEN each  decoded operands.
REQ-008 opcode  input  7; funct3  input  3; funct7b5  input  1  instruction fields.
REQ-009 rd  input  5  destination register index.
REQ-010 out_valid  output  1  head entry valid toward ALU.
REQ-011 out_ready  input  1  downstream consumes head entry.
REQ-012 d1, d2  output  XLEN  ALU operands; control  output  4  ALU operation code.
REQ-013 rd_out  output  5; illegal  output  1  unsupported opcode flag.

Function
REQ-014 Stage SHALL be a 2-entry FIFO (skid buffer) of decoded ALU packets {d1,d2,control,rd,illegal}.
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready SHALL be 1 when count<2, 0 when count==2 (registered-count based, no combinational path from out_ready).
REQ-017 out_valid SHALL be 1 when count>0; outputs SHALL show head entry, all outputs from flops.
REQ-018 Latency: pushed instruction appears on outputs the cycle after push when FIFO was empty.
REQ-019 Simultaneous push and pop with count==1: count stays 1, head becomes the new entry next cycle.
REQ-020 Pop with count==2: second entry becomes head; push blocked that cycle (in_ready=0).
REQ-021 flush SHALL clear count to 0 next cycle and drop any same-cycle push; flush overrides push/pop.
REQ-022 Decode OP (0110011): funct3 000 -> ADD, or SUB if funct7b5; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7b5; 110 OR; 111 AND; d1=rs1_data, d2=rs2_data.
REQ-023 Decode OP-IMM (0010011): as OP but funct3 000 always ADD (funct7b5 ignored); d2=imm.
REQ-024 LUI (0110111): d1=0, d2=imm, ADD. AUIPC (0010111): d1=pc, d2=imm, ADD.
REQ-025 Any other opcode: illegal=1, control=ADD, d1=rs1_data, d2=rs2_data; entry still flows normally.
REQ-026 Control encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001; 1010-1111 never produced.
REQ-027 Internal pointers SHALL be 1 bit and wrap modulo 2.

Reset
REQ-028 On rst assertion, immediately: count=0, pointers=0, out_valid=0, in_ready=1.
REQ-029 During reset d1, d2, rd_out, illegal SHALL be 0 and control SHALL be 0000.
REQ-030 Reset mid-operation SHALL discard all held entries; no entry reappears after release.

Structure
REQ-031 Shared package SHALL hold XLEN default, ALU control enum (REQ-026), opcode constants and packet struct.
REQ-032 Combinational decoder SHALL be a separate sub-module alu_decode (fields+operands in, packet out).
REQ-033 The ALU SHALL consume d1/d2/control directly; no logic between this stage and the ALU.

Verification
REQ-034 Empty FIFO, push OP funct3=000 funct7b5=1 rs1=10 rs2=3, out_ready=1 -> next cycle out_valid=1, d1=10, d2=3, control=0001.
REQ-035 out_ready=0, push three instructions back to back -> in_ready=0 after second push, third not accepted, first two popped in order once out_ready=1.
REQ-036 AUIPC pc=0x1000 imm=0x2000 -> d1=0x1000, d2=0x2000, control=0000; LUI imm=0xABCDE000 -> d1=0, d2=0xABCDE000.
REQ-037 OP-IMM funct3=000 funct7b5=1 -> control=0000; funct3=101 funct7b5=1 -> 0111; opcode 1111111 -> illegal=1.
REQ-038 count==2 with flush and in_valid both asserted -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-039 Assert rst asynchronously between clock edges with count==1 -> out_valid falls without a clock edge, all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU control encoding, RV32I opcodes,
// and the control half of the decoded packet carried through the skid buffer.
package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Operand buses are kept outside the struct so XLEN stays a module parameter.
  typedef struct packed {
    alu_ctrl_e  control;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_pkt_t;

  localparam ctrl_pkt_t CTRL_PKT_RESET = '{control: ALU_ADD, rd: 5'd0, illegal: 1'b0};

  // Register-register ops honour funct7b5 for SUB; immediate ops only for SRA.
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3,
                                       input logic       funct7b5,
                                       input logic       allow_sub);
    alu_ctrl_e op;
    unique case (funct3)
      3'b000:  op = (funct7b5 && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_decode.sv
// Combinational decoder: instruction fields and operands in, ALU packet out.
module alu_decode
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic [4:0]      rd_i,
  output logic [XLEN-1:0] d1_o,
  output logic [XLEN-1:0] d2_o,
  output ctrl_pkt_t       pkt_o
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    d1_o          = rs1_data_i;
    d2_o          = rs2_data_i;
    pkt_o.control = ALU_ADD;
    pkt_o.rd      = rd_i;
    pkt_o.illegal = 1'b0;
    unique case (opcode_i)
      OPC_OP:     pkt_o.control = alu_op(funct3_i, funct7b5_i, 1'b1);
      OPC_OP_IMM: begin
        d2_o          = imm_i;
        pkt_o.control = alu_op(funct3_i, funct7b5_i, 1'b0);
      end
      OPC_LUI: begin
        d1_o = '0;
        d2_o = imm_i;
      end
      OPC_AUIPC: begin
        d1_o = pc_i;
        d2_o = imm_i;
      end
      default:    pkt_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes ALU instructions and holds them in a
// 2-entry skid FIFO whose outputs feed the ALU directly from flops.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] d1,
  output logic [XLEN-1:0] d2,
  output logic [3:0]      control,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  logic [XLEN-1:0] dec_d1;
  logic [XLEN-1:0] dec_d2;
  ctrl_pkt_t       dec_pkt;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .pc_i       (pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .imm_i      (imm),
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .rd_i       (rd),
    .d1_o       (dec_d1),
    .d2_o       (dec_d2),
    .pkt_o      (dec_pkt)
  );

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] d1_q  [2];
  logic [XLEN-1:0] d2_q  [2];
  ctrl_pkt_t       pkt_q [2];

  logic push;
  logic pop;

  // Handshakes depend only on the registered count, never on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage is reset because it drives the outputs directly and they
  // must read zero while rst is high; at two entries this is cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        d1_q[i]  <= '0;
        d2_q[i]  <= '0;
        pkt_q[i] <= CTRL_PKT_RESET;
      end
    end else if (push) begin
      d1_q[wr_ptr_q]  <= dec_d1;
      d2_q[wr_ptr_q]  <= dec_d2;
      pkt_q[wr_ptr_q] <= dec_pkt;
    end
  end

  assign d1      = d1_q[rd_ptr_q];
  assign d2      = d2_q[rd_ptr_q];
  assign control = pkt_q[rd_ptr_q].control;
  assign rd_out  = pkt_q[rd_ptr_q].rd;
  assign illegal = pkt_q[rd_ptr_q].illegal;

endmodule
